// File: rtl/gpa_fhdo_seq_ctrl.sv
// Timed sample sequencer: fetches 4-channel words from a sync-read RAM
// and dispatches one per interval tick to gpa_fhdo_iface.
module gpa_fhdo_seq_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 24,
  parameter int TMR_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic [TMR_W-1:0]    interval_i,
  input  logic [ADDR_W-1:0]   end_addr_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  input  logic [4*DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0]   datax_o,
  output logic [DATA_W-1:0]   datay_o,
  output logic [DATA_W-1:0]   dataz_o,
  output logic [DATA_W-1:0]   dataz2_o,
  output logic                valid_o,
  input  logic                busy_i,
  output logic                running_o,
  output logic                done_o,
  output logic                underrun_o,
  output logic [ADDR_W:0]     sample_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_CAPT,
    S_WAIT
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   end_q;
  logic [TMR_W-1:0]    interval_q;
  logic [TMR_W-1:0]    timer_q;
  logic                pending_q;
  logic                ready_q;
  logic [ADDR_W:0]     cnt_q;
  logic                underrun_q;
  logic                running_q;
  logic                valid_q;
  logic                done_q;
  logic [4*DATA_W-1:0] hold_q;
  logic [4*DATA_W-1:0] out_q;

  logic                tick;
  logic                disp;
  logic                pending_d;
  logic [TMR_W-1:0]    ivl_clamp;

  assign tick = (state_q != S_IDLE) && (timer_q == '0);
  assign disp = (state_q == S_WAIT) && pending_q
             && ready_q && !busy_i;
  // A tick landing on an already-pending slot is dropped, not queued
  assign pending_d = (pending_q & ~disp)
                   | (tick & ~pending_q);
  assign ivl_clamp = (interval_i < TMR_W'(2))
                   ? TMR_W'(2) : interval_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      end_q      <= '0;
      interval_q <= '0;
      timer_q    <= '0;
      pending_q  <= 1'b0;
      ready_q    <= 1'b0;
      cnt_q      <= '0;
      underrun_q <= 1'b0;
      running_q  <= 1'b0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      hold_q     <= '0;
      out_q      <= '0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (stop_i) begin
        state_q   <= S_IDLE;
        running_q <= 1'b0;
        pending_q <= 1'b0;
        ready_q   <= 1'b0;
      end else if (state_q == S_IDLE) begin
        if (start_i) begin
          interval_q <= ivl_clamp;
          end_q      <= end_addr_i;
          addr_q     <= '0;
          timer_q    <= ivl_clamp;
          cnt_q      <= '0;
          underrun_q <= 1'b0;
          running_q  <= 1'b1;
          pending_q  <= 1'b0;
          ready_q    <= 1'b0;
          state_q    <= S_FETCH;
        end
      end else begin
        timer_q   <= tick ? interval_q
                          : timer_q - 1'b1;
        pending_q <= pending_d;
        if (tick && (pending_q || busy_i))
          underrun_q <= 1'b1;
        unique case (state_q)
          S_FETCH: state_q <= S_CAPT;
          S_CAPT: begin
            hold_q  <= mem_data_i;
            ready_q <= 1'b1;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (disp) begin
              valid_q <= 1'b1;
              out_q   <= hold_q;
              ready_q <= 1'b0;
              cnt_q   <= cnt_q + 1'b1;
              if (addr_q == end_q) begin
                done_q    <= 1'b1;
                running_q <= 1'b0;
                state_q   <= S_IDLE;
              end else begin
                addr_q  <= addr_q + 1'b1;
                state_q <= S_FETCH;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign mem_addr_o   = addr_q;
  assign datax_o      = out_q[0*DATA_W +: DATA_W];
  assign datay_o      = out_q[1*DATA_W +: DATA_W];
  assign dataz_o      = out_q[2*DATA_W +: DATA_W];
  assign dataz2_o     = out_q[3*DATA_W +: DATA_W];
  assign valid_o      = valid_q;
  assign running_o    = running_q;
  assign done_o       = done_q;
  assign underrun_o   = underrun_q;
  assign sample_cnt_o = cnt_q;

endmodule

// File: tb/tb_gpa_fhdo_seq_ctrl.sv
// Directed bench for gpa_fhdo_seq_ctrl with hand-computed
// dispatch times (relative to the start edge) and data.
module tb_gpa_fhdo_seq_ctrl;

  localparam int AW = 10;
  localparam int DW = 24;
  localparam int TW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_i;
  logic            stop_i;
  logic [TW-1:0]   interval_i;
  logic [AW-1:0]   end_addr_i;
  logic [AW-1:0]   mem_addr_o;
  logic [4*DW-1:0] mem_data_i;
  logic [DW-1:0]   datax_o;
  logic [DW-1:0]   datay_o;
  logic [DW-1:0]   dataz_o;
  logic [DW-1:0]   dataz2_o;
  logic            valid_o;
  logic            busy_i;
  logic            running_o;
  logic            done_o;
  logic            underrun_o;
  logic [AW:0]     sample_cnt_o;

  gpa_fhdo_seq_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .TMR_W(TW)
  ) dut (
    .clk(clk), .rst(rst),
    .start_i(start_i), .stop_i(stop_i),
    .interval_i(interval_i),
    .end_addr_i(end_addr_i),
    .mem_addr_o(mem_addr_o),
    .mem_data_i(mem_data_i),
    .datax_o(datax_o), .datay_o(datay_o),
    .dataz_o(dataz_o), .dataz2_o(dataz2_o),
    .valid_o(valid_o), .busy_i(busy_i),
    .running_o(running_o), .done_o(done_o),
    .underrun_o(underrun_o),
    .sample_cnt_o(sample_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [4*DW-1:0] word(input int a);
    logic [DW-1:0] x, y, z, z2;
    x  = DW'(32'h100000 + a);
    y  = DW'(32'h200000 + a);
    z  = DW'(32'h300000 + a);
    z2 = DW'(32'h400000 + a);
    return {z2, z, y, x};
  endfunction

  logic [4*DW-1:0] ram [0:15];
  initial for (int i = 0; i < 16; i++) ram[i] = word(i);
  always @(posedge clk) mem_data_i <= ram[mem_addr_o[3:0]];

  int edge_n = 0;
  int t0 = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int              v_t[$];
  logic [4*DW-1:0] v_d[$];
  int              d_t[$];

  always @(negedge clk) begin
    if (valid_o) begin
      v_t.push_back(edge_n - t0 - 1);
      v_d.push_back({dataz2_o, dataz_o, datay_o, datax_o});
    end
    if (done_o) d_t.push_back(edge_n - t0 - 1);
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h",
                  tag, obs, exp);
  endtask

  // returns on the falling edge right after the start edge (rel 0)
  task automatic do_start(input logic [TW-1:0] ivl,
                          input logic [AW-1:0] ea,
                          input bit with_stop);
    @(negedge clk);
    v_t.delete();
    v_d.delete();
    d_t.delete();
    interval_i = ivl;
    end_addr_i = ea;
    start_i    = 1'b1;
    stop_i     = with_stop;
    t0         = edge_n;
    @(negedge clk);
    start_i = 1'b0;
    stop_i  = 1'b0;
  endtask

  task automatic chk_run(input string tag, input int n,
                         input int t[4], input int a[4],
                         input int dt);
    chk($sformatf("%s.npulse", tag), v_t.size(), n);
    for (int i = 0; i < n && i < v_t.size(); i++) begin
      chk($sformatf("%s.t%0d", tag, i), v_t[i], t[i]);
      chk($sformatf("%s.d%0d", tag, i), v_d[i], word(a[i]));
    end
    chk($sformatf("%s.ndone", tag), d_t.size(), 1);
    if (d_t.size() > 0)
      chk($sformatf("%s.tdone", tag), d_t[0], dt);
  endtask

  initial begin
    rst        = 1'b1;
    start_i    = 1'b0;
    stop_i     = 1'b0;
    busy_i     = 1'b0;
    interval_i = '0;
    end_addr_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst.valid", valid_o, 0);
    chk("rst.run", running_o, 0);
    chk("rst.done", done_o, 0);
    chk("rst.und", underrun_o, 0);
    chk("rst.cnt", sample_cnt_o, 0);
    chk("rst.data", {dataz2_o, dataz_o, datay_o, datax_o}, 0);
    chk("rst.addr", mem_addr_o, 0);

    // nominal playback, interval 9
    do_start(16'd9, 10'd3, 1'b0);
    chk("t1.run", running_o, 1);
    repeat (50) @(negedge clk);
    chk_run("t1", 4, '{11, 21, 31, 41}, '{0, 1, 2, 3}, 41);
    chk("t1.und", underrun_o, 0);
    chk("t1.run_end", running_o, 0);
    chk("t1.cnt", sample_cnt_o, 4);
    chk("t1.addr", mem_addr_o, 3);

    // interval 0 clamps to 2 -> period 3
    do_start(16'd0, 10'd3, 1'b0);
    repeat (30) @(negedge clk);
    chk_run("t2", 4, '{4, 7, 10, 13}, '{0, 1, 2, 3}, 13);
    chk("t2.und", underrun_o, 0);

    // busy across tick 2 only
    do_start(16'd9, 10'd3, 1'b0);
    repeat (12) @(negedge clk);
    busy_i = 1'b1;
    repeat (15) @(negedge clk);
    busy_i = 1'b0;
    repeat (30) @(negedge clk);
    chk_run("t3", 4, '{11, 28, 31, 41}, '{0, 1, 2, 3}, 41);
    chk("t3.und", underrun_o, 1);

    // busy across ticks 2 and 3 -> tick 3 dropped
    do_start(16'd9, 10'd3, 1'b0);
    chk("t4.und0", underrun_o, 0);
    repeat (12) @(negedge clk);
    busy_i = 1'b1;
    repeat (20) @(negedge clk);
    busy_i = 1'b0;
    repeat (13) @(negedge clk);
    chk("t4.cnt45", sample_cnt_o, 3);
    chk("t4.und45", underrun_o, 1);
    repeat (20) @(negedge clk);
    chk_run("t4", 4, '{11, 33, 41, 51}, '{0, 1, 2, 3}, 51);
    chk("t4.und_sticky", underrun_o, 1);

    // stop in WAIT of sample 2
    do_start(16'd9, 10'd3, 1'b0);
    chk("t5.und_clr", underrun_o, 0);
    repeat (15) @(negedge clk);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
    chk("t5.run", running_o, 0);
    chk("t5.valid", valid_o, 0);
    repeat (40) @(negedge clk);
    chk("t5.npulse", v_t.size(), 1);
    chk("t5.ndone", d_t.size(), 0);
    chk("t5.cnt", sample_cnt_o, 1);
    chk("t5.addr", mem_addr_o, 1);

    // replay from 0 with end 0 -> exactly one sample
    do_start(16'd9, 10'd0, 1'b0);
    repeat (30) @(negedge clk);
    chk_run("t5b", 1, '{11, 0, 0, 0}, '{0, 0, 0, 0}, 11);
    chk("t5b.addr", mem_addr_o, 0);
    chk("t5b.cnt", sample_cnt_o, 1);

    // reset mid-sequence
    do_start(16'd9, 10'd3, 1'b0);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6.run", running_o, 0);
    chk("t6.cnt", sample_cnt_o, 0);
    chk("t6.data", {dataz2_o, dataz_o, datay_o, datax_o}, 0);
    chk("t6.addr", mem_addr_o, 0);
    repeat (30) @(negedge clk);
    chk("t6.npulse", v_t.size(), 1);

    // start and stop together in IDLE
    do_start(16'd9, 10'd3, 1'b1);
    chk("t6b.run0", running_o, 0);
    repeat (20) @(negedge clk);
    chk("t6b.npulse", v_t.size(), 0);
    chk("t6b.ndone", d_t.size(), 0);
    chk("t6b.run", running_o, 0);
    chk("t6b.cnt", sample_cnt_o, 0);
    chk("t6b.addr", mem_addr_o, 0);
    chk("t6b.und", underrun_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
